// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled 8N1 UART receiver with done/error strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_receiver #(
  parameter int NB_DATA      = 8,
  parameter int N_TICKS      = 16,
  parameter int BAUD_DIVISOR = 651,
  parameter int NB_DIVISOR   = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_rx_error,
  output logic               o_busy
);
  localparam int NB_SCNT = $clog2(N_TICKS);
  localparam int NB_BCNT = $clog2(NB_DATA);
  localparam logic [NB_DIVISOR-1:0] DIV_LAST = NB_DIVISOR'(BAUD_DIVISOR - 1);
  localparam logic [NB_SCNT-1:0]    S_MID    = NB_SCNT'(N_TICKS / 2 - 1);
  localparam logic [NB_SCNT-1:0]    S_LAST   = NB_SCNT'(N_TICKS - 1);
  localparam logic [NB_BCNT-1:0]    B_LAST   = NB_BCNT'(NB_DATA - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, RECOVER
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t               state_q, state_d;
  logic                 rx_m, rx_s, tick;
  logic [NB_DIVISOR-1:0] tick_cnt;
  logic [NB_SCNT-1:0]   s_cnt_q, s_cnt_d;
  logic [NB_BCNT-1:0]   b_cnt_q, b_cnt_d;
  logic [NB_DATA-1:0]   shift_q, shift_d, data_d;
  logic                 done_d, err_d, par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  assign par_bad = par_q;
`else
  assign par_bad = 1'b0;
`endif

  assign tick   = tick_cnt == DIV_LAST;
  assign o_busy = state_q != IDLE;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      tick_cnt   <= '0;
      state_q    <= IDLE;
      s_cnt_q    <= '0;
      b_cnt_q    <= '0;
      shift_q    <= '0;
      o_rx_data  <= '0;
      o_rx_done  <= 1'b0;
      o_rx_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      rx_m       <= i_rx;
      rx_s       <= rx_m;
      tick_cnt   <= tick ? '0 : tick_cnt + 1'b1;
      state_q    <= state_d;
      s_cnt_q    <= s_cnt_d;
      b_cnt_q    <= b_cnt_d;
      shift_q    <= shift_d;
      o_rx_data  <= data_d;
      o_rx_done  <= done_d;
      o_rx_error <= err_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    b_cnt_d = b_cnt_q;
    shift_d = shift_q;
    data_d  = o_rx_data;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        s_cnt_d = '0;
      end
      START: if (tick) begin
        s_cnt_d = s_cnt_q + 1'b1;
        if (s_cnt_q == S_MID) begin
          state_d = rx_s ? IDLE : DATA;
          s_cnt_d = '0;
          b_cnt_d = '0;
        end
      end
      DATA: if (tick) begin
        s_cnt_d = (s_cnt_q == S_LAST) ? '0 : s_cnt_q + 1'b1;
        if (s_cnt_q == S_LAST) begin
          shift_d = {rx_s, shift_q[NB_DATA-1:1]};
          b_cnt_d = b_cnt_q + 1'b1;
          state_d = (b_cnt_q == B_LAST) ? AFTER_DATA : DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        s_cnt_d = (s_cnt_q == S_LAST) ? '0 : s_cnt_q + 1'b1;
        if (s_cnt_q == S_LAST) begin
          par_d   = ^{shift_q, rx_s};
          state_d = STOP;
        end
      end
`endif
      STOP: if (tick) begin
        s_cnt_d = (s_cnt_q == S_LAST) ? '0 : s_cnt_q + 1'b1;
        if (s_cnt_q == S_LAST) begin
          done_d  = rx_s && !par_bad;
          err_d   = !(rx_s && !par_bad);
          data_d  = (rx_s && !par_bad) ? shift_q : o_rx_data;
          state_d = rx_s ? IDLE : RECOVER;
        end
      end
      // a held-low line must go high before another start bit is honoured
      RECOVER: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: table-driven frames with a strobe scoreboard plus corner-case sequences.
module tb_uart_receiver;
  localparam int BIT = 64;

  logic       clk = 1'b0, i_reset = 1'b1, i_rx = 1'b1;
  logic [7:0] o_rx_data;
  logic       o_rx_done, o_rx_error, o_busy;

  always #5 clk = ~clk;

  uart_receiver #(.NB_DATA(8), .N_TICKS(16), .BAUD_DIVISOR(4), .NB_DIVISOR(10)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_rx(i_rx),
    .o_rx_data(o_rx_data), .o_rx_done(o_rx_done), .o_rx_error(o_rx_error), .o_busy(o_busy)
  );

  typedef struct {logic [7:0] data; logic stop; logic par_ok; logic exp_err; int gap;} vec_t;
  typedef struct {logic err; logic [7:0] data;} exp_t;

  exp_t       sb[$];
  vec_t       tbl[8];
  int         checks = 0, errors = 0;
  logic [7:0] last_good = 8'h00, prev_data = 8'h00;
  logic       rst_d = 1'b1, strobe_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) rst_d <= i_reset;

  always @(negedge clk) begin
    if (o_rx_done || o_rx_error) begin
      check("strobe_exclusive", {31'd0, o_rx_done & o_rx_error}, 32'd0);
      check("strobe_one_cycle", {31'd0, strobe_d}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: done=%0b error=%0b data=%0h, none expected", o_rx_done, o_rx_error, o_rx_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_kind_error", {31'd0, o_rx_error}, {31'd0, e.err});
        check("strobe_data", {24'd0, o_rx_data}, {24'd0, e.data});
      end
    end
    if (o_rx_data !== prev_data && !rst_d) check("data_only_on_done", {31'd0, o_rx_done}, 32'd1);
    prev_data = o_rx_data;
    strobe_d  = o_rx_done | o_rx_error;
  end

  task automatic send_bits(input logic [7:0] d, input logic stop, input logic par_ok);
    i_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    i_rx = ^d ^ ~par_ok;
    repeat (BIT) @(negedge clk);
`endif
    i_rx = stop;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic frame(input vec_t v);
    exp_t e;
    e.err  = v.exp_err;
    e.data = v.exp_err ? last_good : v.data;
    sb.push_back(e);
    if (!v.exp_err) last_good = v.data;
    send_bits(v.data, v.stop, v.par_ok);
    if (v.gap > 0) begin
      i_rx = v.stop;
      repeat (v.gap) @(negedge clk);
      check("busy_after_frame", {31'd0, o_busy}, {31'd0, ~v.stop});
    end
  endtask

  initial begin
    int viol;
    tbl[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 20};
    tbl[1] = '{8'hAA, 1'b1, 1'b1, 1'b0, 0};
    tbl[2] = '{8'hBB, 1'b1, 1'b1, 1'b0, 0};
    tbl[3] = '{8'hCC, 1'b1, 1'b1, 1'b0, 0};
    tbl[4] = '{8'hDD, 1'b1, 1'b1, 1'b0, 20};
    tbl[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 20};
    tbl[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 0};
    tbl[7] = '{8'h7E, 1'b1, 1'b1, 1'b0, 20};

    repeat (3) @(negedge clk);
    check("reset_data", {24'd0, o_rx_data}, 32'd0);
    check("reset_done", {31'd0, o_rx_done}, 32'd0);
    check("reset_error", {31'd0, o_rx_error}, 32'd0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    i_reset = 1'b0;

    viol = 0;
    repeat (200) begin
      @(negedge clk);
      if (o_rx_done || o_rx_error || o_busy || o_rx_data != 8'h00) viol++;
    end
    check("idle_quiet", viol, 0);

    for (int i = 0; i < 8; i++) frame(tbl[i]);

    // glitch shorter than half a bit
    i_rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy", {31'd0, o_busy}, 32'd1);
    repeat (6) @(negedge clk);
    i_rx = 1'b1;
    for (int i = 0; i < 40 && o_busy; i++) @(negedge clk);
    check("glitch_busy_clears", {31'd0, o_busy}, 32'd0);
    repeat (BIT) @(negedge clk);
    frame('{8'h01, 1'b1, 1'b1, 1'b0, 20});

    // framing error followed by a break
    frame('{8'h3C, 1'b0, 1'b1, 1'b1, 0});
    repeat (200) @(negedge clk);
    check("break_busy", {31'd0, o_busy}, 32'd1);
    i_rx = 1'b1;
    repeat (20) @(negedge clk);
    check("break_released", {31'd0, o_busy}, 32'd0);
    check("data_kept_after_error", {24'd0, o_rx_data}, 32'h01);
    frame('{8'hFF, 1'b1, 1'b1, 1'b0, 20});

    // reset in the middle of 0x11's data bits
    i_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    i_rx = 1'b1;
    repeat (BIT) @(negedge clk);
    i_rx = 1'b0;
    repeat (BIT + BIT / 2) @(negedge clk);
    i_reset = 1'b1;
    i_rx = 1'b1;
    @(negedge clk);
    check("midreset_data", {24'd0, o_rx_data}, 32'd0);
    check("midreset_done", {31'd0, o_rx_done}, 32'd0);
    check("midreset_error", {31'd0, o_rx_error}, 32'd0);
    check("midreset_busy", {31'd0, o_busy}, 32'd0);
    i_reset = 1'b0;
    last_good = 8'h00;
    repeat (2 * BIT) @(negedge clk);
    frame('{8'h22, 1'b1, 1'b1, 1'b0, 20});

`ifdef UART_RX_PARITY_EN
    frame('{8'h07, 1'b1, 1'b0, 1'b1, 20});
    frame('{8'h07, 1'b1, 1'b1, 1'b0, 20});
`endif

    repeat (100) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
